// File: rtl/systolic_feeder_if.sv
// Operand write port, launch handshake and skewed feed outputs of the
// systolic feeder; names carry the feeder's own direction (_i in, _o out).
interface systolic_feeder_if #(
  parameter int unsigned N = 8
);
  logic         wr_en_i;
  logic         wr_sel_i;
  logic [1:0]   wr_row_i;
  logic [1:0]   wr_col_i;
  logic [N-1:0] wr_data_i;
  logic         start_i;
  logic         busy_o;
  logic         done_o;
  logic         output_sign_o;
  logic [N-1:0] feed_row_0_o, feed_row_1_o, feed_row_2_o, feed_row_3_o;
  logic [N-1:0] feed_col_0_o, feed_col_1_o, feed_col_2_o, feed_col_3_o;

  modport master (
    output wr_en_i, wr_sel_i, wr_row_i, wr_col_i, wr_data_i, start_i,
    input  busy_o, done_o, output_sign_o,
    input  feed_row_0_o, feed_row_1_o, feed_row_2_o, feed_row_3_o,
    input  feed_col_0_o, feed_col_1_o, feed_col_2_o, feed_col_3_o
  );

  modport slave (
    input  wr_en_i, wr_sel_i, wr_row_i, wr_col_i, wr_data_i, start_i,
    output busy_o, done_o, output_sign_o,
    output feed_row_0_o, feed_row_1_o, feed_row_2_o, feed_row_3_o,
    output feed_col_0_o, feed_col_1_o, feed_col_2_o, feed_col_3_o
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand store and skewed stream driver for a 4x4 output-stationary PE array:
// feeds A rows / B columns diagonally, drains, then raises output_sign to shift C out.
module systolic_feeder #(
  parameter int unsigned N         = 8,
  parameter int unsigned DIM       = 4,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  systolic_feeder_if.slave   bus
);

  localparam int unsigned FEED_CYC = 2 * DIM - 1;
  localparam int unsigned AW       = $clog2(DIM);
  localparam int unsigned CW       = $clog2(FEED_CYC + DRAIN_CYC + DIM + 1);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_SHIFT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q [DIM][DIM];
  logic [N-1:0]    a_d [DIM][DIM];
  logic [N-1:0]    b_q [DIM][DIM];
  logic [N-1:0]    b_d [DIM][DIM];
  logic [N-1:0]    row_q [DIM];
  logic [N-1:0]    row_d [DIM];
  logic [N-1:0]    col_q [DIM];
  logic [N-1:0]    col_d [DIM];
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            osign_q, osign_d;

  // Next state, phase counter and operand memory (writes only land in IDLE).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (bus.wr_en_i) begin
          if (bus.wr_sel_i) b_d[AW'(bus.wr_row_i)][AW'(bus.wr_col_i)] = bus.wr_data_i;
          else              a_d[AW'(bus.wr_row_i)][AW'(bus.wr_col_i)] = bus.wr_data_i;
        end
        if (bus.start_i) begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        if (cnt_q == CW'(FEED_CYC - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == CW'(DIM - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the upcoming state and memory so the registered
  // feeds show t=0 in the first busy cycle, including a same-edge write.
  always_comb begin : p_out
    int t;
    t       = int'(cnt_d);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    osign_d = (state_d == S_SHIFT);
    row_d   = '{default: '0};
    col_d   = '{default: '0};
    for (int i = 0; i < int'(DIM); i++) begin
      if (state_d == S_FEED && t >= i && (t - i) < int'(DIM)) begin
        row_d[AW'(i)] = a_d[AW'(i)][AW'(t - i)];
        col_d[AW'(i)] = b_d[AW'(t - i)][AW'(i)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      row_q   <= '{default: '0};
      col_q   <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      osign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      row_q   <= row_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      osign_q <= osign_d;
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.output_sign_o = osign_q;
  assign bus.feed_row_0_o  = row_q[0];
  assign bus.feed_row_1_o  = row_q[1];
  assign bus.feed_row_2_o  = row_q[2];
  assign bus.feed_row_3_o  = row_q[3];
  assign bus.feed_col_0_o  = col_q[0];
  assign bus.feed_col_1_o  = col_q[1];
  assign bus.feed_col_2_o  = col_q[2];
  assign bus.feed_col_3_o  = col_q[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares; a PE-array model checks shift-out.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(8)) bus ();

  systolic_feeder #(.N(8), .DIM(4), .DRAIN_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    int         fld;
    logic [7:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [19:0] exp_c[$];
  logic [19:0] cap_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          e2e_on = 1'b0;
  logic [7:0]  ma [4][4];
  logic [7:0]  mb [4][4];
  string fname [11] = '{"busy", "done", "output_sign",
                        "feed_row_0", "feed_row_1", "feed_row_2", "feed_row_3",
                        "feed_col_0", "feed_col_1", "feed_col_2", "feed_col_3"};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] row_of(int i);
    case (i)
      0: return bus.feed_row_0_o;
      1: return bus.feed_row_1_o;
      2: return bus.feed_row_2_o;
      default: return bus.feed_row_3_o;
    endcase
  endfunction

  function automatic logic [7:0] col_of(int j);
    case (j)
      0: return bus.feed_col_0_o;
      1: return bus.feed_col_1_o;
      2: return bus.feed_col_2_o;
      default: return bus.feed_col_3_o;
    endcase
  endfunction

  function automatic logic [7:0] dut_field(int f);
    case (f)
      0: return {7'd0, bus.busy_o};
      1: return {7'd0, bus.done_o};
      2: return {7'd0, bus.output_sign_o};
      3, 4, 5, 6: return row_of(f - 3);
      default: return col_of(f - 7);
    endcase
  endfunction

  // Behavioural output-stationary PE array driven by the feeder.
  logic [7:0]  pa [4][4];
  logic [7:0]  pb [4][4];
  logic [19:0] pc [4][4];

  function automatic logic [7:0] a_in(int i, int j);
    if (j == 0) return row_of(i);
    return pa[i][j-1];
  endfunction

  function automatic logic [7:0] b_in(int i, int j);
    if (i == 0) return col_of(j);
    return pb[i-1][j];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pa <= '{default: '0};
      pb <= '{default: '0};
      pc <= '{default: '0};
    end else if (bus.output_sign_o) begin
      for (int i = 0; i < 4; i++) begin
        if (e2e_on) cap_q.push_back(pc[i][3]);
        for (int j = 3; j > 0; j--) pc[i][j] <= pc[i][j-1];
        pc[i][0] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          pa[i][j] <= a_in(i, j);
          pb[i][j] <= b_in(i, j);
          pc[i][j] <= pc[i][j] + 20'(a_in(i, j)) * 20'(b_in(i, j));
        end
      end
    end
  end

  // Monitor: compare every queued expectation due this cycle.
  int          k;
  logic [7:0]  got;
  logic [19:0] gc, wc;
  always @(negedge clk) begin
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].cyc == cyc) begin
        total++;
        got = dut_field(sb[k].fld);
        if (got !== sb[k].val) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h", fname[sb[k].fld], cyc, got, sb[k].val);
        end
        sb.delete(k);
      end else if (sb[k].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL stale_%s cyc=%0d got=none want=%h", fname[sb[k].fld], sb[k].cyc, sb[k].val);
        sb.delete(k);
      end else begin
        k++;
      end
    end
    while (cap_q.size() > 0) begin
      gc = cap_q.pop_front();
      total++;
      if (exp_c.size() == 0) begin
        bad++;
        $display("FAIL shift_out_extra cyc=%0d got=%h want=none", cyc, gc);
      end else begin
        wc = exp_c.pop_front();
        if (gc !== wc) begin
          bad++;
          $display("FAIL shift_out cyc=%0d got=%h want=%h", cyc, gc, wc);
        end
      end
    end
  end

  task automatic expect_at(int c, int f, logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  // Expected outputs for cycles 1..upto after a start edge taken at cycle s.
  task automatic push_seq(int s, int upto);
    for (int n = 1; n <= 17; n++) begin
      if (n <= upto) begin
        int t;
        t = n - 1;
        expect_at(s + n, 0, (n <= 16) ? 8'd1 : 8'd0);
        expect_at(s + n, 1, (n == 16) ? 8'd1 : 8'd0);
        expect_at(s + n, 2, (n >= 12 && n <= 15) ? 8'd1 : 8'd0);
        for (int i = 0; i < 4; i++) begin
          logic [7:0] r, c;
          r = 8'h00;
          c = 8'h00;
          if (n <= 7 && t - i >= 0 && t - i < 4) begin
            r = ma[i][t-i];
            c = mb[t-i][i];
          end
          expect_at(s + n, 3 + i, r);
          expect_at(s + n, 7 + i, c);
        end
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic write_el(bit sel, int r, int c, logic [7:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_sel_i  = sel;
    bus.wr_row_i  = 2'(r);
    bus.wr_col_i  = 2'(c);
    bus.wr_data_i = d;
    if (sel) mb[r][c] = d;
    else     ma[r][c] = d;
    next();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic launch(input int upto, output int s);
    s = cyc;
    push_seq(s, upto);
    bus.start_i = 1'b1;
    next();
    bus.start_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, s2;
    rst           = 1'b1;
    bus.wr_en_i   = 1'b0;
    bus.wr_sel_i  = 1'b0;
    bus.wr_row_i  = 2'd0;
    bus.wr_col_i  = 2'd0;
    bus.wr_data_i = 8'h00;
    bus.start_i   = 1'b0;
    ma = '{default: '0};
    mb = '{default: '0};
    for (int f = 0; f < 11; f++) begin
      expect_at(1, f, 8'h00);
      expect_at(2, f, 8'h00);
    end
    next();
    next();
    rst = 1'b0;
    next();

    // Reset in the middle of FEED with A all 8'h11.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) write_el(1'b0, i, j, 8'h11);
    launch(2, s);
    next();
    next();
    #1 rst = 1'b1;
    for (int f = 0; f < 11; f++) expect_at(s + 3, f, 8'h00);
    for (int n = 4; n <= 17; n++) begin
      expect_at(s + n, 0, 8'h00);
      expect_at(s + n, 1, 8'h00);
    end
    next();
    next();
    rst = 1'b0;
    ma = '{default: '0};
    mb = '{default: '0};
    repeat (13) next();
    launch(17, s);
    repeat (17) next();

    // Skew pattern.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        write_el(1'b0, i, j, 8'(8'h10 * i + j));
        write_el(1'b1, i, j, 8'(8'h40 + 8'h10 * i + j));
      end
    launch(17, s);
    expect_at(s + 1, 3, 8'h00);
    expect_at(s + 1, 7, 8'h40);
    expect_at(s + 4, 4, 8'h12);
    expect_at(s + 4, 6, 8'h30);
    expect_at(s + 4, 9, 8'h52);
    expect_at(s + 7, 6, 8'h33);
    expect_at(s + 7, 10, 8'h73);
    expect_at(s + 7, 3, 8'h00);
    repeat (17) next();

    // Write and start during DRAIN are ignored; back-to-back relaunch.
    launch(17, s);
    expect_at(s + 16, 1, 8'h01);
    expect_at(s + 17, 0, 8'h00);
    repeat (7) next();
    bus.wr_en_i   = 1'b1;
    bus.wr_sel_i  = 1'b0;
    bus.wr_row_i  = 2'd0;
    bus.wr_col_i  = 2'd0;
    bus.wr_data_i = 8'hFF;
    bus.start_i   = 1'b1;
    next();
    bus.wr_en_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (8) next();
    launch(17, s2);
    expect_at(s2 + 1, 3, 8'h00);
    expect_at(s2 + 1, 0, 8'h01);
    repeat (17) next();

    // Same-edge write of B[0][0] with start.
    bus.wr_en_i   = 1'b1;
    bus.wr_sel_i  = 1'b1;
    bus.wr_row_i  = 2'd0;
    bus.wr_col_i  = 2'd0;
    bus.wr_data_i = 8'h5A;
    mb[0][0]      = 8'h5A;
    launch(17, s);
    bus.wr_en_i = 1'b0;
    expect_at(s + 1, 7, 8'h5A);
    repeat (17) next();

    // End to end: identity A so the array shifts out B, row i giving B[i][3..0].
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        write_el(1'b0, i, j, (i == j) ? 8'h01 : 8'h00);
        write_el(1'b1, i, j, 8'(i * 4 + j + 1));
      end
    for (int sh = 0; sh < 4; sh++)
      for (int i = 0; i < 4; i++) exp_c.push_back(20'(i * 4 + (3 - sh) + 1));
    e2e_on = 1'b1;
    launch(17, s);
    repeat (17) next();
    e2e_on = 1'b0;
    repeat (3) next();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_checks got=%0d want=0", sb.size());
    end
    if (exp_c.size() != 0) begin
      total++;
      bad++;
      $display("FAIL shift_out_count got=%0d_missing want=0", exp_c.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Input-side driver for the 4x4 output-stationary PE array.
- Holds operand matrices A (4x4) and B (4x4), loaded over a simple write port.
- On start, streams A rows into the array's left edge and B columns into its top edge with the diagonal skew the array needs.
- Then flushes the pipeline and holds the output-shift control high so the array shifts its accumulated C values out of its right edge.

Parameters:
- N, 8, data width of each matrix element and of each feed port
- DIM, 4, array dimension (rows = cols = inner dimension)
- DRAIN_CYC, 4, zero-feed cycles between last operand and shift-out (must be >= DIM)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- wr_en  input  1  write strobe for operand memory
- wr_sel  input  1  0 = write A, 1 = write B
- wr_row  input  2  element row index
- wr_col  input  2  element column index
- wr_data  input  N  element value
- start  input  1  launch one matrix-multiply sequence
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when the shift-out window ends
- feed_row_0..feed_row_3  output  N each  A stream into array row 0..3 (left edge)
- feed_col_0..feed_col_3  output  N each  B stream into array column 0..3 (top edge)
- output_sign  output  1  drives the array's OutputSign; high during the shift-out window

Behaviour:
- Reset values (async, on rst high):
  - state = IDLE
  - all feed outputs = 0
  - output_sign = 0, busy = 0, done = 0
  - cycle counter = 0
  - A and B memories cleared to 0
- All outputs are registered.
- Write port:
  - When state == IDLE and wr_en is high, the element is written at the clock edge.
  - wr_en in any other state is ignored and leaves memory unchanged.
- FSM states: IDLE -> FEED -> DRAIN -> SHIFT -> DONE -> IDLE.
- IDLE:
  - Feeds are 0, output_sign = 0.
  - start high at an edge moves to FEED with counter t = 0.
  - If wr_en and start are high on the same edge, the write commits and the new value is used by the sequence.
- FEED: lasts 2*DIM-1 cycles (7), with t = 0..6.
  - feed_row_i = A[i][t-i] if 0 <= t-i < DIM, else 0.
  - feed_col_j = B[t-j][j] if 0 <= t-j < DIM, else 0.
  - Example: in cycle t=0 only feed_row_0 = A[0][0] and feed_col_0 = B[0][0] are nonzero.
  - In cycle t=6 only feed_row_3 = A[3][3] and feed_col_3 = B[3][3] are nonzero.
- DRAIN: DRAIN_CYC cycles; all feeds = 0, output_sign = 0. This lets the last operands reach PE(3,3) and accumulate.
- SHIFT: DIM cycles; all feeds = 0, output_sign = 1.
- DONE: one cycle; done = 1, output_sign = 0, feeds = 0. Next state is IDLE.
- Output timing:
  - busy = 1 in FEED, DRAIN, SHIFT and DONE, 0 otherwise.
  - busy rises in the first cycle after the start edge.
  - The first feed values appear in that same cycle.
- Total latency, start edge to done pulse: 7 + DRAIN_CYC + DIM + 1 = 16 cycles with defaults.
- start while busy is ignored: no restart, no queuing.
- Back-to-back operation: start sampled in the cycle after done (state IDLE) launches a new sequence normally.
- Data is passed through bit-exact, with no sign handling or arithmetic. Values are zero-padded outside the skew window.
- rst asserted mid-sequence:
  - All outputs drop to 0 immediately (asynchronously).
  - Memory is cleared and state returns to IDLE.
  - No done pulse is produced.

Test Plan:
- Reset: assert rst mid-FEED with A = all 8'h11 -> feeds, output_sign, busy and done read 0 immediately; after release, a start with no writes streams only zeros.
- Skew check: load A[i][k] = 8'h10*i + k and B[k][j] = 8'h40 + 8'h10*k + j, then pulse start -> at t=0 feed_row_0 = 8'h00 and feed_col_0 = 8'h40, all others 0; at t=3 feed_row_1 = 8'h12, feed_row_3 = 8'h30, feed_col_2 = 8'h52; at t=6 only feed_row_3 = 8'h33 and feed_col_3 = 8'h73.
- Sequence timing: start at edge 0 -> busy high cycles 1-16; output_sign high in exactly cycles 12-15; done pulses only in cycle 16; busy low in cycle 17.
- Ignored inputs: write A[0][0] = 8'hFF and pulse start during DRAIN -> sequence completes unchanged at cycle 16 with no restart; a second run still streams the original A[0][0].
- Same-edge write and start: in IDLE, write B[0][0] = 8'h5A together with start -> feed_col_0 = 8'h5A at t=0.
- End-to-end with PE array model: A = identity, B[k][j] = k*4 + j + 1 -> the 16 values shifted out during output_sign equal B, in the array's row-shift order.
